wt_dcache_miss_resp: RTL and testbench

// - Single-port miss responder: serves the read-port miss interface (miss_req/ack/replay/rtrn_vld) of the WT dcache controller.
// - Accepts one miss at a time, checks for a cacheline collision with an in-flight write, issues a memory read, then refills the cache or returns NC data.
// - Sits between the dcache read controller, the cache memory write port and the L1.5/AXI adapter.

---
 rtl/wt_dcache_miss_resp.sv | 143 ++++++++++++++
 tb/tb_wt_dcache_miss_resp.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wt_dcache_miss_resp.sv
// wt_dcache_miss_resp: single-outstanding read-miss handler for the WT dcache (collision check, memory read, refill/NC return).
// Define WT_DCACHE_MISS_STATS_EN to add saturating miss/replay counters.
module wt_dcache_miss_resp #(
    parameter int unsigned          Plen       = 56,
    parameter int unsigned          SetAssoc   = 8,
    parameter int unsigned          LineWidth  = 512,
    parameter int unsigned          IndexWidth = 12,
    parameter int unsigned          IdWidth    = 3,
    parameter logic [IdWidth-1:0]   MemTxId    = IdWidth'(1),
    parameter logic [7:0]           LfsrSeed   = 8'hA5
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           miss_req_i,
    output logic                           miss_ack_o,
    output logic                           miss_replay_o,
    input  logic [Plen-1:0]                miss_paddr_i,
    input  logic                           miss_nc_i,
    input  logic [2:0]                     miss_size_i,
    input  logic [SetAssoc-1:0]            miss_vld_bits_i,
    input  logic [IdWidth-1:0]             miss_id_i,
    output logic                           miss_rtrn_vld_o,
    output logic [IdWidth-1:0]             miss_rtrn_id_o,
    output logic [63:0]                    miss_rtrn_data_o,
    input  logic                           wr_pend_vld_i,
    input  logic [Plen-1:0]                wr_pend_paddr_i,
    output logic                           mem_req_o,
    input  logic                           mem_gnt_i,
    output logic [Plen-1:0]                mem_paddr_o,
    output logic [2:0]                     mem_size_o,
    output logic                           mem_nc_o,
    output logic [IdWidth-1:0]             mem_id_o,
    input  logic                           mem_rtrn_vld_i,
    input  logic [IdWidth-1:0]             mem_rtrn_id_i,
    input  logic [LineWidth-1:0]           mem_rtrn_data_i,
    output logic                           wr_cl_vld_o,
    output logic [SetAssoc-1:0]            wr_cl_way_o,
    output logic [Plen-IndexWidth-1:0]     wr_cl_tag_o,
    output logic [IndexWidth-$clog2(LineWidth/8)-1:0] wr_cl_idx_o,
    output logic [LineWidth-1:0]           wr_cl_data_o
`ifdef WT_DCACHE_MISS_STATS_EN
    ,
    output logic [31:0]                    stat_miss_cnt_o,
    output logic [31:0]                    stat_replay_cnt_o
`endif
);
    localparam int unsigned OffW = $clog2(LineWidth/8);
    localparam int unsigned WayW = $clog2(SetAssoc);
    localparam logic [Plen-1:0] LineMask = {{(Plen-OffW){1'b1}}, {OffW{1'b0}}};

    typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, REFILL} state_e;

    state_e                 state_q, state_d;
    logic [Plen-1:0]        paddr_q;
    logic                   nc_q;
    logic [2:0]             size_q;
    logic [SetAssoc-1:0]    vld_q;
    logic [IdWidth-1:0]     id_q;
    logic [LineWidth-1:0]   data_q;
    logic [7:0]             lfsr_q;
    logic                   idle, refill, coll, rtrn_hit;
    logic [WayW-1:0]        inv_idx;
    logic [SetAssoc-1:0]    way;

    assign idle     = state_q == IDLE;
    assign refill   = state_q == REFILL;
    assign coll     = wr_pend_vld_i && ~|((wr_pend_paddr_i ^ miss_paddr_i) & LineMask);
    assign rtrn_hit = mem_rtrn_vld_i && mem_rtrn_id_i == MemTxId;

    assign miss_ack_o    = idle && miss_req_i && !coll;
    assign miss_replay_o = idle && miss_req_i && coll;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = miss_ack_o ? MEM_REQ : IDLE;
            MEM_REQ:  state_d = mem_gnt_i ? MEM_WAIT : MEM_REQ;
            MEM_WAIT: state_d = rtrn_hit ? REFILL : MEM_WAIT;
            default:  state_d = IDLE;
        endcase
    end

    // Prefer the lowest invalid way; fall back to pseudo-random when the set is full.
    always_comb begin
        inv_idx = '0;
        for (int i = SetAssoc - 1; i >= 0; i--) if (!vld_q[i]) inv_idx = WayW'(i);
        way = '0;
        way[&vld_q ? lfsr_q[WayW-1:0] : inv_idx] = 1'b1;
    end

    assign mem_req_o   = state_q == MEM_REQ;
    assign mem_paddr_o = nc_q ? paddr_q : (paddr_q & LineMask);
    assign mem_size_o  = size_q;
    assign mem_nc_o    = nc_q;
    assign mem_id_o    = MemTxId;

    assign miss_rtrn_vld_o  = refill;
    assign miss_rtrn_id_o   = refill ? id_q : '0;
    assign miss_rtrn_data_o = refill ? data_q[paddr_q[OffW-1:3]*64 +: 64] : '0;

    assign wr_cl_vld_o  = refill && !nc_q;
    assign wr_cl_way_o  = wr_cl_vld_o ? way : '0;
    assign wr_cl_tag_o  = wr_cl_vld_o ? paddr_q[Plen-1:IndexWidth] : '0;
    assign wr_cl_idx_o  = wr_cl_vld_o ? paddr_q[IndexWidth-1:OffW] : '0;
    assign wr_cl_data_o = wr_cl_vld_o ? data_q : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            paddr_q <= '0;
            nc_q    <= 1'b0;
            size_q  <= '0;
            vld_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            lfsr_q  <= LfsrSeed;
        end else begin
            state_q <= state_d;
            if (miss_ack_o) begin
                paddr_q <= miss_paddr_i;
                nc_q    <= miss_nc_i;
                size_q  <= miss_size_i;
                vld_q   <= miss_vld_bits_i;
                id_q    <= miss_id_i;
            end
            if (state_q == MEM_WAIT && rtrn_hit) data_q <= mem_rtrn_data_i;
            // x^8+x^6+x^5+x^4+1, stepped only by cacheable refills
            if (wr_cl_vld_o) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

`ifdef WT_DCACHE_MISS_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_miss_cnt_o   <= '0;
            stat_replay_cnt_o <= '0;
        end else begin
            if (miss_ack_o && ~&stat_miss_cnt_o) stat_miss_cnt_o <= stat_miss_cnt_o + 32'd1;
            if (miss_replay_o && ~&stat_replay_cnt_o) stat_replay_cnt_o <= stat_replay_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_wt_dcache_miss_resp.sv
// tb_wt_dcache_miss_resp: table-driven collision vectors plus directed miss sequences for wt_dcache_miss_resp.
module tb_wt_dcache_miss_resp;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         miss_req = 1'b0, miss_nc = 1'b0;
    logic [55:0]  miss_paddr = '0, wr_pend_paddr = '0;
    logic [2:0]   miss_size = '0, miss_id = '0, mem_rtrn_id = '0;
    logic [7:0]   miss_vld_bits = '0;
    logic         wr_pend_vld = 1'b0, mem_gnt = 1'b0, mem_rtrn_vld = 1'b0;
    logic [511:0] mem_rtrn_data = '0;
    logic         miss_ack, miss_replay, miss_rtrn_vld, mem_req, mem_nc, wr_cl_vld;
    logic [2:0]   miss_rtrn_id, mem_size, mem_id;
    logic [63:0]  miss_rtrn_data;
    logic [55:0]  mem_paddr;
    logic [7:0]   wr_cl_way;
    logic [43:0]  wr_cl_tag;
    logic [5:0]   wr_cl_idx;
    logic [511:0] wr_cl_data;
`ifdef WT_DCACHE_MISS_STATS_EN
    logic [31:0]  stat_miss_cnt, stat_replay_cnt;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wt_dcache_miss_resp #(.MemTxId(3'd1), .LfsrSeed(8'hA5)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .miss_req_i(miss_req), .miss_ack_o(miss_ack), .miss_replay_o(miss_replay),
        .miss_paddr_i(miss_paddr), .miss_nc_i(miss_nc), .miss_size_i(miss_size),
        .miss_vld_bits_i(miss_vld_bits), .miss_id_i(miss_id),
        .miss_rtrn_vld_o(miss_rtrn_vld), .miss_rtrn_id_o(miss_rtrn_id), .miss_rtrn_data_o(miss_rtrn_data),
        .wr_pend_vld_i(wr_pend_vld), .wr_pend_paddr_i(wr_pend_paddr),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_paddr_o(mem_paddr), .mem_size_o(mem_size),
        .mem_nc_o(mem_nc), .mem_id_o(mem_id),
        .mem_rtrn_vld_i(mem_rtrn_vld), .mem_rtrn_id_i(mem_rtrn_id), .mem_rtrn_data_i(mem_rtrn_data),
        .wr_cl_vld_o(wr_cl_vld), .wr_cl_way_o(wr_cl_way), .wr_cl_tag_o(wr_cl_tag),
        .wr_cl_idx_o(wr_cl_idx), .wr_cl_data_o(wr_cl_data)
`ifdef WT_DCACHE_MISS_STATS_EN
        , .stat_miss_cnt_o(stat_miss_cnt), .stat_replay_cnt_o(stat_replay_cnt)
`endif
    );

    typedef struct {
        logic        req;
        logic [55:0] paddr;
        logic        pend;
        logic [55:0] pend_paddr;
        logic        ack;
        logic        replay;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] mkline(input logic [31:0] seed);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = {seed, 32'(k)};
        return l;
    endfunction

    // Full miss with immediate grant and return on the following cycle; ends in the refill cycle.
    task automatic run_miss(input string nm, input logic [55:0] a, input logic nc, input logic [2:0] sz,
                            input logic [7:0] vld, input logic [2:0] id, input logic [31:0] seed,
                            input logic [7:0] exp_way, input logic chain);
        logic [511:0] ln;
        ln = mkline(seed);
        @(posedge clk); #1;
        miss_req = 1'b1; miss_paddr = a; miss_nc = nc; miss_size = sz;
        miss_vld_bits = vld; miss_id = id; wr_pend_vld = 1'b0;
        @(negedge clk);
        chk({nm, ".ack"}, miss_ack, 1);
        chk({nm, ".replay"}, miss_replay, 0);
        chk({nm, ".idle_rtrn"}, miss_rtrn_vld, 0);
        @(posedge clk); #1;
        miss_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        chk({nm, ".mem_req"}, mem_req, 1);
        chk({nm, ".mem_paddr"}, mem_paddr, nc ? a : {a[55:6], 6'b0});
        chk({nm, ".mem_nc"}, mem_nc, nc);
        chk({nm, ".mem_size"}, mem_size, sz);
        chk({nm, ".mem_id"}, mem_id, 3'd1);
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rtrn_vld = 1'b1; mem_rtrn_id = 3'd1; mem_rtrn_data = ln;
        @(negedge clk);
        chk({nm, ".wait_req"}, mem_req, 0);
        chk({nm, ".wait_rtrn"}, miss_rtrn_vld, 0);
        @(posedge clk); #1;
        mem_rtrn_vld = 1'b0; mem_rtrn_data = '0; miss_req = chain;
        @(negedge clk);
        chk({nm, ".rtrn_vld"}, miss_rtrn_vld, 1);
        chk({nm, ".rtrn_id"}, miss_rtrn_id, id);
        chk({nm, ".rtrn_data"}, miss_rtrn_data, {seed, 29'b0, a[5:3]});
        chk({nm, ".wr_cl_vld"}, wr_cl_vld, !nc);
        if (!nc) begin
            chk({nm, ".way"}, wr_cl_way, exp_way);
            chk({nm, ".tag"}, wr_cl_tag, a[55:12]);
            chk({nm, ".idx"}, wr_cl_idx, a[11:6]);
            chk({nm, ".cl_data"}, wr_cl_data, ln);
        end
        if (chain) chk({nm, ".refill_no_ack"}, miss_ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 56'h8000_1048, 1'b0, 56'h0,         1'b0, 1'b0};
        vecs[1] = '{1'b1, 56'h8000_1048, 1'b0, 56'h8000_1060, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 56'h8000_1048, 1'b1, 56'h8000_1060, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 56'h8000_1048, 1'b1, 56'h8000_1080, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 56'h8000_1048, 1'b1, 56'h8000_1040, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 56'h8000_1048, 1'b1, 56'h8000_107F, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 56'h8000_1048, 1'b1, 56'h8000_103F, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 56'h8000_1048, 1'b1, 56'h1000_1048, 1'b1, 1'b0};

        #1;
        chk("rst.mem_id", mem_id, 3'd1);
        chk("rst.outs", {miss_ack, miss_replay, miss_rtrn_vld, mem_req, mem_nc, wr_cl_vld}, 0);
        chk("rst.paddr", mem_paddr, 0);
        chk("rst.way", wr_cl_way, 0);
        chk("rst.rtrn_data", miss_rtrn_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // IDLE decisions only: the request is dropped before the next edge.
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            miss_req = vecs[i].req; miss_paddr = vecs[i].paddr;
            wr_pend_vld = vecs[i].pend; wr_pend_paddr = vecs[i].pend_paddr;
            #2;
            chk($sformatf("vec%0d.ack", i), miss_ack, vecs[i].ack);
            chk($sformatf("vec%0d.replay", i), miss_replay, vecs[i].replay);
            chk($sformatf("vec%0d.mem_req", i), mem_req, 0);
            miss_req = 1'b0; wr_pend_vld = 1'b0;
        end

        // Full set: victims follow LFSR A5 -> 4A -> 95 -> 2A -> 54.
        run_miss("lfsr0", 56'h8000_2000, 1'b0, 3'b111, 8'hFF, 3'd2, 32'h1111_0000, 8'h20, 1'b0);
        run_miss("lfsr1", 56'h8000_2040, 1'b0, 3'b111, 8'hFF, 3'd3, 32'h2222_0000, 8'h04, 1'b0);
        run_miss("lfsr2", 56'h8000_2080, 1'b0, 3'b111, 8'hFF, 3'd4, 32'h3333_0000, 8'h20, 1'b0);
        run_miss("lfsr3", 56'h8000_20C0, 1'b0, 3'b111, 8'hFF, 3'd5, 32'h4444_0000, 8'h04, 1'b0);
        run_miss("nc", 56'h1000_0008, 1'b1, 3'd3, 8'hFF, 3'd6, 32'h5555_0000, 8'h00, 1'b0);
        run_miss("lfsr4", 56'h8000_2100, 1'b0, 3'b111, 8'hFF, 3'd7, 32'h6666_0000, 8'h10, 1'b0);
        run_miss("cache", 56'h8000_1048, 1'b0, 3'b111, 8'h0F, 3'd2, 32'h7777_0000, 8'h10, 1'b1);
        run_miss("chain", 56'h8000_3010, 1'b0, 3'b111, 8'h0F, 3'd3, 32'h8888_0000, 8'h10, 1'b0);

        // Foreign-id return ignored; matching return two cycles later.
        @(posedge clk); #1;
        miss_req = 1'b1; miss_paddr = 56'h8000_4018; miss_nc = 1'b0; miss_vld_bits = 8'h0F; miss_id = 3'd5;
        @(negedge clk); chk("fid.ack", miss_ack, 1);
        @(posedge clk); #1; miss_req = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1; mem_gnt = 1'b0; mem_rtrn_vld = 1'b1; mem_rtrn_id = 3'd2; mem_rtrn_data = mkline(32'hBAD0_0000);
        @(negedge clk); chk("fid.wait0", miss_rtrn_vld, 0);
        @(posedge clk); #1; mem_rtrn_vld = 1'b0;
        @(negedge clk); chk("fid.ignored", {miss_rtrn_vld, wr_cl_vld, mem_req}, 0);
        @(posedge clk); #1; mem_rtrn_vld = 1'b1; mem_rtrn_id = 3'd1; mem_rtrn_data = mkline(32'h9999_0000);
        @(negedge clk); chk("fid.wait2", miss_rtrn_vld, 0);
        @(posedge clk); #1; mem_rtrn_vld = 1'b0;
        @(negedge clk);
        chk("fid.rtrn_vld", miss_rtrn_vld, 1);
        chk("fid.rtrn_id", miss_rtrn_id, 3'd5);
        chk("fid.rtrn_data", miss_rtrn_data, {32'h9999_0000, 32'd3});
        chk("fid.way", wr_cl_way, 8'h10);

        // Replay on collision, ack once the write drains, then reset while waiting on memory.
        @(posedge clk); #1;
        miss_req = 1'b1; miss_paddr = 56'h8000_1048; miss_id = 3'd1;
        wr_pend_vld = 1'b1; wr_pend_paddr = 56'h8000_1060;
        @(negedge clk);
        chk("rep.replay", miss_replay, 1);
        chk("rep.no_ack", miss_ack, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("rep.no_mem_req", mem_req, 0);
        chk("rep.still_replay", miss_replay, 1);
        wr_pend_vld = 1'b0;
        #1 chk("rep.ack", miss_ack, 1);
        chk("rep.ack_no_replay", miss_replay, 0);
        @(posedge clk); #1; miss_req = 1'b0;
        @(negedge clk); chk("rep.req_held0", mem_req, 1);
        @(posedge clk); #1; mem_gnt = 1'b1;
        @(negedge clk); chk("rep.req_held1", mem_req, 1);
        chk("rep.paddr", mem_paddr, 56'h8000_1040);
        @(posedge clk); #1; mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstmid.outs", {miss_ack, miss_replay, miss_rtrn_vld, mem_req, mem_nc, wr_cl_vld}, 0);
        chk("rstmid.paddr", mem_paddr, 0);
        chk("rstmid.size", mem_size, 0);
        chk("rstmid.mem_id", mem_id, 3'd1);
        @(posedge clk); #1; rst_n = 1'b1;
        run_miss("post_rst", 56'h8000_5008, 1'b0, 3'd3, 8'hFF, 3'd4, 32'hAAAA_0000, 8'h20, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); chk("post_rst.done", {miss_rtrn_vld, mem_req}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
